// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector with two internal line buffers.
// Raster pixels in over valid/ready; interior gradient results out over valid/ready.
// Build option: define SOBEL_MAG_OUT_EN to emit saturated |gx|+|gy| instead of
// thresholded binary edges. Ports and latency are the same in both builds.
module sobel_stream #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W+2:0] thresh,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_eof
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned GW = PIX_W + 4;
  localparam int unsigned MW = PIX_W + 3;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [MW-1:0]    thresh_frame;
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];
  logic [PIX_W-1:0] win [9];
  logic             win_valid;
  logic             win_eof;
  logic [GW-1:0]    gx_c;
  logic [GW-1:0]    gy_c;
  logic [GW-1:0]    s1_gx;
  logic [GW-1:0]    s1_gy;
  logic             s1_valid;
  logic             s1_eof;
  logic [GW-1:0]    abs_x_c;
  logic [GW-1:0]    abs_y_c;
  logic [MW-1:0]    mag_c;
  logic [PIX_W-1:0] res_c;
  logic             advance;
  logic             accept;

  // Whole pipeline moves unless the output register is holding a refused result
  assign advance  = !out_valid || out_ready;
  assign in_ready = !rst && advance;
  assign accept   = in_valid && in_ready;

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Threshold captured with the first pixel of each frame
  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_frame <= '0;
    end else if (accept && col == '0 && row == '0) begin
      thresh_frame <= thresh;
    end
  end

  // Line buffers and 3x3 window shift on accept; contents need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= in_data;
      lb2[col] <= lb1[col];
      win[0]   <= win[1];
      win[1]   <= win[2];
      win[2]   <= lb2[col];
      win[3]   <= win[4];
      win[4]   <= win[5];
      win[5]   <= lb1[col];
      win[6]   <= win[7];
      win[7]   <= win[8];
      win[8]   <= in_data;
    end
  end

  // Window stage flags: a full 3x3 neighbourhood exists from row 2, col 2 on
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_eof   <= 1'b0;
    end else if (advance) begin
      win_valid <= accept && row >= RW'(2) && col >= CW'(2);
      win_eof   <= accept && row == RW'(IMG_H - 1) && col == CW'(IMG_W - 1);
    end
  end

  // Gradients in two's complement; GW bits cannot overflow for 8*(2^PIX_W-1)
  assign gx_c = (GW'(win[2]) + (GW'(win[5]) << 1) + GW'(win[8]))
              - (GW'(win[0]) + (GW'(win[3]) << 1) + GW'(win[6]));
  assign gy_c = (GW'(win[6]) + (GW'(win[7]) << 1) + GW'(win[8]))
              - (GW'(win[0]) + (GW'(win[1]) << 1) + GW'(win[2]));

`ifndef SOBEL_MAG_OUT_EN
  logic [MW-1:0] s1_thr;

  // Threshold travels with its frame's results so back-to-back frames stay separate
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_thr <= '0;
    end else if (advance) begin
      s1_thr <= thresh_frame;
    end
  end
`endif

  // S1: registered gradients plus valid/eof tags
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_eof   <= 1'b0;
      s1_gx    <= '0;
      s1_gy    <= '0;
    end else if (advance) begin
      s1_valid <= win_valid;
      s1_eof   <= win_eof;
      s1_gx    <= gx_c;
      s1_gy    <= gy_c;
    end
  end

  // Magnitude and output value selection
  assign abs_x_c = s1_gx[GW-1] ? -s1_gx : s1_gx;
  assign abs_y_c = s1_gy[GW-1] ? -s1_gy : s1_gy;
  assign mag_c   = MW'(abs_x_c) + MW'(abs_y_c);
`ifdef SOBEL_MAG_OUT_EN
  assign res_c = (|mag_c[MW-1:PIX_W]) ? {PIX_W{1'b1}} : mag_c[PIX_W-1:0];
`else
  assign res_c = (mag_c >= s1_thr) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`endif

  // S2: output register, held stable while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eof   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_eof   <= s1_valid && s1_eof;
      if (s1_valid) begin
        out_data <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on a 5x4 image (6 interior outputs per frame).
// Expected values follow the SOBEL_MAG_OUT_EN build when that macro is defined.
module tb_sobel_stream;
  localparam int W    = 5;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] thresh = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_eof;

  int   n_run  = 0;
  int   n_fail = 0;
  bit   rand_ready = 1'b0;
  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];
  logic [7:0] cur [NPIX];

  always #5 clk = ~clk;

  sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .thresh    (thresh),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_eof   (out_eof)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Edge-build value or magnitude-build value
  function automatic logic [7:0] pick(input logic [7:0] edge_v, input logic [7:0] mag_v);
`ifdef SOBEL_MAG_OUT_EN
    return mag_v;
`else
    return edge_v;
`endif
  endfunction

  function automatic logic [7:0] pix_of(input int pat, input int r, input int c);
    case (pat)
      0:       return 8'(c * 10);
      1:       return (c >= 2) ? 8'd20  : 8'd0;
      2:       return (c >= 2) ? 8'd255 : 8'd0;
      3:       return (c <  2) ? 8'd255 : 8'd0;
      4:       return (r >= 2) ? 8'd200 : 8'd0;
      5:       return (r <  2) ? 8'd200 : 8'd0;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic int px(input int r, input int c);
    return int'(cur[r * W + c]);
  endfunction

  // Reference Sobel written by coordinates
  function automatic logic [7:0] model(input int r, input int c, input int t);
    int gx, gy, mag;
    gx = px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1)
       - px(r-1, c-1) - 2 * px(r, c-1) - px(r+1, c-1);
    gy = px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1)
       - px(r-1, c-1) - 2 * px(r-1, c) - px(r-1, c+1);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_MAG_OUT_EN
    return (mag > 255) ? 8'd255 : 8'(mag);
`else
    return (mag >= t) ? 8'd255 : 8'd0;
`endif
  endfunction

  task automatic push_model(input int t);
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++)
        exp_q.push_back({(r == H - 2 && c == W - 2), model(r, c, t)});
  endtask

  // Both interior rows share the same per-column results
  task automatic push_hand(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({1'b0, a});
      exp_q.push_back({1'b0, b});
      exp_q.push_back({(r == 1), c});
    end
  endtask

  task automatic send_px(input logic [7:0] d, input logic [10:0] t, input bit gaps);
    bit ok;
    int guard;
    if (gaps)
      while ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    in_valid = 1'b1;
    in_data  = d;
    thresh   = t;
    guard    = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
      guard++;
      if (guard > 1000) begin
        chk("accept_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Non-first pixels carry a different thresh to prove it is sampled only at (0,0)
  task automatic send_range(input int pat, input logic [10:0] t, input bit gaps,
                            input int lo, input int hi);
    logic [7:0] d;
    for (int i = lo; i <= hi; i++) begin
      d = pix_of(pat, i / W, i % W);
      cur[i] = d;
      send_px(d, (i == 0) ? t : ~t, gaps);
    end
  endtask

  task automatic compare_out(input string tag);
    int guard;
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // Downstream readiness
  initial forever begin
    @(posedge clk); #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output capture and stall-hold check
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && prev_stall)
        chk("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
      prev_stall = !rst && out_valid && !out_ready;
      prev_data  = out_data;
      if (!rst && out_valid && out_ready) got_q.push_back({out_eof, out_data});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_eof",   out_eof,   0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // Ramp (col*10), thresh 0: mag 80 everywhere; latency measured on pixel (2,2)
    send_range(0, 11'd0, 1'b0, 0, 12);
    @(posedge clk); #1;
    chk("lat_n1_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_n2_valid", out_valid, 1);
    chk("lat_n2_data",  out_data,  pick(8'd255, 8'd80));
    chk("lat_n2_eof",   out_eof,   0);
    send_range(0, 11'd0, 1'b0, 13, NPIX - 1);
    push_hand(pick(8'd255, 8'd80), pick(8'd255, 8'd80), pick(8'd255, 8'd80));
    compare_out("ramp_thr0");

    // Back-to-back frames with per-frame thresholds and boundary magnitudes
    send_range(0, 11'd81, 1'b0, 0, NPIX - 1);
    push_hand(pick(8'd0, 8'd80), pick(8'd0, 8'd80), pick(8'd0, 8'd80));
    send_range(0, 11'd80, 1'b0, 0, NPIX - 1);
    push_hand(pick(8'd255, 8'd80), pick(8'd255, 8'd80), pick(8'd255, 8'd80));
    send_range(1, 11'd60, 1'b0, 0, NPIX - 1);
    push_hand(pick(8'd255, 8'd80), pick(8'd255, 8'd80), 8'd0);
    send_range(2, 11'd1020, 1'b0, 0, NPIX - 1);
    push_hand(8'd255, 8'd255, 8'd0);
    send_range(3, 11'd1020, 1'b0, 0, NPIX - 1);
    push_hand(8'd255, 8'd255, 8'd0);
    send_range(4, 11'd801, 1'b0, 0, NPIX - 1);
    push_hand(pick(8'd0, 8'd255), pick(8'd0, 8'd255), pick(8'd0, 8'd255));
    send_range(5, 11'd800, 1'b0, 0, NPIX - 1);
    push_hand(8'd255, 8'd255, 8'd255);
    compare_out("b2b");

    // Random pixels, random in_valid gaps and random out_ready
    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      t = $urandom_range(0, 1023);
      send_range(6, 11'(t), 1'b1, 0, NPIX - 1);
      push_model(t);
    end
    compare_out("random");
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame with results in flight, then a full fresh frame
    send_range(0, 11'd0, 1'b0, 0, 13);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready",  in_ready,  0);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    chk("midrst_in_ready_after", in_ready, 1);
    @(posedge clk); #1;
    send_range(1, 11'd60, 1'b0, 0, NPIX - 1);
    push_hand(pick(8'd255, 8'd80), pick(8'd255, 8'd80), 8'd0);
    compare_out("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
